// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-shares one hex-to-7-segment decoder across DIGITS displays,
// capturing each decoded pattern into a per-digit output register.
module hex_scan_ctrl #(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [2:0]            wr_idx,
    input  logic [3:0]            wr_data,
    input  logic                  wr_blank,
    output logic [3:0]            dec_nibble,
    input  logic [6:0]            dec_seg,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic [2:0]            cur_idx,
    output logic                  frame_done
);
    localparam int CW = $clog2(SCAN_DIV + 1);
    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;
    state_t              state;
    logic [3:0]          value [DIGITS];
    logic [DIGITS-1:0]   blank;
    logic [CW-1:0]       cnt;
    logic                wr_ok, last, restart;
    assign wr_ok   = wr_en && (int'(wr_idx) < DIGITS);
    assign last    = int'(cur_idx) == DIGITS - 1;
    // a write to the digit on the decoder restarts its settle window so the new value is shown
    assign restart = wr_ok && (wr_idx == cur_idx) && (state != IDLE);
    always_ff @(posedge clk) begin
        if (reset) begin
            value      <= '{default: 4'h0};
            blank      <= '1;
            hex_out    <= '1;
            dec_nibble <= 4'h0;
            cur_idx    <= 3'd0;
            frame_done <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
        end else begin
            if (wr_ok) begin
                value[wr_idx] <= wr_data;
                blank[wr_idx] <= wr_blank;
            end
            dec_nibble <= value[cur_idx];
            frame_done <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (restart) begin
                state <= DRIVE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= DRIVE;
                        cnt   <= '0;
                    end
                    DRIVE: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(SCAN_DIV - 1))
                            state <= CAPTURE;
                    end
                    CAPTURE: begin
                        hex_out[7*cur_idx +: 7] <= blank[cur_idx] ? 7'h7F : dec_seg;
                        cur_idx    <= last ? 3'd0 : cur_idx + 3'd1;
                        frame_done <= last;
                        cnt        <= '0;
                        state      <= DRIVE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed stimulus with a capture/frame scoreboard checked by a separate monitor.
module tb_hex_scan_ctrl;
    localparam int D = 6;
    logic clk = 0, reset = 1, enable = 0, wr_en = 0, wr_blank = 0;
    logic [2:0] wr_idx = 0, cur_idx;
    logic [3:0] wr_data = 0, dec_nibble;
    logic [6:0] dec_seg;
    logic [7*D-1:0] hex_out;
    logic frame_done;
    int ntests = 0, nfail = 0, cyc = 0;
    typedef struct {int idx; logic [6:0] seg; int cyc;} item_t;
    item_t q[$];
    int fq[$];
    logic [6:0] exp_seg [D];
    int prev_idx = 0;
    logic prev_fd = 0;

    hex_scan_ctrl #(.DIGITS(D), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .wr_blank(wr_blank), .dec_nibble(dec_nibble), .dec_seg(dec_seg),
        .hex_out(hex_out), .cur_idx(cur_idx), .frame_done(frame_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction
    assign dec_seg = seg7(dec_nibble);

    function automatic logic [7*D-1:0] pack();
        logic [7*D-1:0] r;
        for (int k = 0; k < D; k++) r[7*k +: 7] = exp_seg[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // monitor: a change of cur_idx marks a capture of the previous digit
    always @(negedge clk) begin
        if (!reset) begin
            if (cur_idx != 3'(prev_idx) && q.size() > 0 && q[0].idx == prev_idx) begin
                ntests++;
                if (hex_out[7*prev_idx +: 7] !== q[0].seg || (q[0].cyc != 0 && cyc != q[0].cyc)) begin
                    nfail++;
                    $display("FAIL capture digit %0d: got seg %0h at cycle %0d expected seg %0h at cycle %0d",
                             prev_idx, hex_out[7*prev_idx +: 7], cyc, q[0].seg, q[0].cyc);
                end
                void'(q.pop_front());
            end
            if (frame_done) begin
                ntests++;
                if (prev_fd) begin
                    nfail++;
                    $display("FAIL frame_done pulse: high for 2 cycles at cycle %0d, expected 1", cyc);
                end
                if (fq.size() > 0) begin
                    ntests++;
                    if (cyc != fq[0]) begin
                        nfail++;
                        $display("FAIL frame_done time: got cycle %0d expected %0d", cyc, fq[0]);
                    end
                    void'(fq.pop_front());
                end
            end
        end
        prev_idx = int'(cur_idx);
        prev_fd  = frame_done;
    end

    task automatic wr(input int idx, input int data, input logic blank);
        wr_en = 1; wr_idx = 3'(idx); wr_data = 4'(data); wr_blank = blank;
        @(posedge clk); #1;
        wr_en = 0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((q.size() > 0 || fq.size() > 0) && n < 150) begin
            @(posedge clk); #1; n++;
        end
        ntests++;
        if (q.size() > 0 || fq.size() > 0) begin
            nfail++;
            $display("FAIL %s timeout: %0d captures and %0d frames outstanding, expected 0", name, q.size(), fq.size());
            q.delete(); fq.delete();
        end
    endtask

    task automatic wait_idx(input int k, output int at);
        int n = 0;
        while (cur_idx == 3'(k) && n < 100) begin @(posedge clk); #1; n++; end
        while (cur_idx != 3'(k) && n < 100) begin @(posedge clk); #1; n++; end
        at = cyc;
        ntests++;
        if (n >= 100) begin
            nfail++;
            $display("FAIL wait cur_idx %0d: got %0d expected %0d", k, cur_idx, k);
        end
    endtask

    initial begin
        int t0, ec;
        for (int k = 0; k < D; k++) exp_seg[k] = 7'h7F;
        repeat (3) @(posedge clk); #1;
        chk("reset hex_out", 64'(hex_out), 64'(pack()));
        chk("reset cur_idx", 64'(cur_idx), 0);
        chk("reset frame_done", 64'(frame_done), 0);
        chk("reset dec_nibble", 64'(dec_nibble), 0);
        reset = 0;
        @(posedge clk); #1;
        // all digits blanked: every capture is 7F, first at edge 6, frames at 31/61
        enable = 1; t0 = cyc;
        for (int k = 0; k < D; k++) q.push_back('{k, 7'h7F, t0 + 6 + 5*k});
        fq.push_back(t0 + 31); fq.push_back(t0 + 61);
        wait_empty("blank frames");
        wr(0, 0, 0); q.push_back('{0, 7'h40, 0});
        wr(1, 8, 0); q.push_back('{1, 7'h00, 0});
        wait_empty("digits 0/1");
        exp_seg[0] = 7'h40; exp_seg[1] = 7'h00;
        chk("hex_out after 0/8", 64'(hex_out), 64'(pack()));
        wr(7, 3, 0); wr(6, 3, 0);
        repeat (62) @(posedge clk); #1;
        chk("hex_out after idx>=DIGITS writes", 64'(hex_out), 64'(pack()));
        wait_idx(2, ec);
        repeat (3) @(posedge clk); #1;
        wr(2, 1, 0);
        q.push_back('{2, 7'h79, ec + 9});
        wait_empty("restart digit 2");
        exp_seg[2] = 7'h79;
        wait_idx(3, ec);
        @(posedge clk); #1;
        enable = 0;
        wr(3, 5, 0);
        repeat (9) @(posedge clk); #1;
        chk("disabled cur_idx", 64'(cur_idx), 3);
        chk("disabled hex_out", 64'(hex_out), 64'(pack()));
        enable = 1;
        q.push_back('{3, 7'h12, cyc + 6});
        wait_empty("resume digit 3");
        exp_seg[3] = 7'h12;
        chk("hex_out after resume", 64'(hex_out), 64'(pack()));
        repeat (7) @(posedge clk); #1;
        reset = 1; wr_en = 1; wr_idx = 3'd4; wr_data = 4'h9; wr_blank = 0;
        @(posedge clk); #1;
        for (int k = 0; k < D; k++) exp_seg[k] = 7'h7F;
        chk("mid reset hex_out", 64'(hex_out), 64'(pack()));
        chk("mid reset cur_idx", 64'(cur_idx), 0);
        chk("mid reset frame_done", 64'(frame_done), 0);
        chk("mid reset dec_nibble", 64'(dec_nibble), 0);
        reset = 0; wr_en = 0;
        q.push_back('{0, 7'h7F, 0}); q.push_back('{4, 7'h7F, 0});
        wait_empty("post reset blank");
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
